prf_regfile_mp: RTL and testbench
=================================

Name: prf_regfile_mp

Overview:
- Parametrised physical register file serving the issue-stage read ports and the retire/writeback write ports.
- Successor to the fixed-size multiported register file. Adds:
  - configurable depth, width and port counts;
  - priority-resolved write conflicts with per-port drop reporting;
  - an optional write-to-read bypass;
  - registered reads with valid strobes;
  - a multi-cycle post-reset clear sequencer gating readiness.

Parameters:
- DEPTH, 64: number of entries (power of 2, ≥8).
- DATA_W, 32: entry width in bits.
- NUM_W, 4: write ports; higher index = younger retire slot.
- NUM_R, 8: read ports (ISSUE_WIDTH_MAX*NUM_SRCS).
- CLR_PER_CYC, 8: entries zeroed per clear cycle (power of 2, divides DEPTH).
- BYPASS_EN, 1: 1 = a same-cycle winning write is forwarded to a matching read.
- ZERO_REG_EN, 1: 1 = entry 0 is hardwired to zero.
- AW, $clog2(DEPTH): address width (derived).

Ports:
- clk  in  1  clock, all logic on the posedge.
- rst_n  in  1  synchronous active-low reset.
- w_en  in  NUM_W  write request per port.
- w_addr  in  NUM_W x AW  write address.
- w_data  in  NUM_W x DATA_W  write data.
- w_drop  out  NUM_W  combinational: enabled write suppressed by a younger same-address write.
- r_en  in  NUM_R  read request per port.
- r_addr  in  NUM_R x AW  read address.
- r_data  out  NUM_R x DATA_W  registered read data.
- r_vld  out  NUM_R  registered: r_data was produced by a read accepted the previous cycle.
- rf_rdy  out  1  registered: clear done, file accepts reads and writes.

Behaviour:
- Reset (rst_n low at a posedge):
  - state goes to CLEAR; clr_ptr=0; rf_rdy=0; r_vld=0; r_data=0.
  - The array is not touched during the reset cycle itself.
- CLEAR state:
  - Each cycle, entries clr_ptr .. clr_ptr+CLR_PER_CYC-1 are written to 0, then clr_ptr += CLR_PER_CYC.
  - After DEPTH/CLR_PER_CYC clear cycles, state goes to READY. rf_rdy=1 from the first cycle in READY.
  - While in CLEAR: w_en and r_en are ignored, w_drop=0, r_vld=0.
  - Reset asserted mid-clear restarts the clear at ptr 0.
- READY state: stays in READY until reset. No other transitions.
- Write resolution (READY):
  - Port i is effective iff w_en[i] is set, and no j>i has w_en[j] with w_addr[j]==w_addr[i], and it is not a write to addr 0 under ZERO_REG_EN.
  - Effective writes update the array at the posedge.
  - w_drop[i]=1 only for the same-address-younger-write case. A write to addr 0 is silently ignored and does not assert w_drop.
- Read (READY), 1-cycle latency:
  - r_en[k] sampled at cycle t gives r_data[k] and r_vld[k]=1 at t+1.
  - The value returned is the array contents before the t-edge writes.
  - With BYPASS_EN=1, if an effective write at t matches r_addr[k], that write's data is returned instead.
  - Addr 0 always returns 0 under ZERO_REG_EN.
  - r_en[k]=0 gives r_vld[k]=0 next cycle, with r_data[k] holding its last value.
- Multiple read ports to the same address are always legal. No read/read conflicts exist.
- Out-of-range addresses cannot occur: DEPTH is a power of 2.
- Writes during the cycle in which rf_rdy first rises are accepted normally.

Test Plan:
- Defaults; rst_n low 2 cycles then high → rf_rdy=0 for exactly 8 cycles, then 1. Reading all 64 addresses returns 0 with r_vld=1 one cycle after each r_en.
- Simultaneous writes: w0(addr5,0xAAAA), w3(addr5,0xBBBB), w1(addr9,0x1111) → w_drop=4'b0001. The next-cycle read of 5 returns 0xBBBB; the read of 9 returns 0x1111.
- BYPASS_EN=1: write addr12=0xDEAD and read addr12 in the same cycle → r_data=0xDEAD next cycle. With BYPASS_EN=0 → prior value 0; a read one cycle later → 0xDEAD.
- Write addr0=0xFFFF_FFFF on w2 → w_drop=0. A read of addr0 returns 0.
- Write 0x1234 to addr40 after ready. Assert rst_n low at clear cycle 3 of a subsequent reset → rf_rdy stays 0 for 8 full cycles after release. The read of addr40 then returns 0. Writes and reads issued during CLEAR produce r_vld=0 and no array change.
- All 8 read ports read addr7=0x77 in one cycle, then r_en=0 next cycle → all r_data=0x77 with r_vld=1. On the following cycle r_vld=0 and r_data holds 0x77.

Source files
------------

// File: rtl/prf_regfile_mp.sv
// Multiported physical register file: priority-resolved writes, optional write-to-read bypass, post-reset clear.
// Latency: reads 1 cycle (registered r_data/r_vld); w_drop is combinational in the request cycle.
// Backpressure: none per port; the whole file is unavailable (requests ignored) until rf_rdy rises.
module prf_regfile_mp #(
    parameter int DEPTH       = 64,
    parameter int DATA_W      = 32,
    parameter int NUM_W       = 4,
    parameter int NUM_R       = 8,
    parameter int CLR_PER_CYC = 8,
    parameter int BYPASS_EN   = 1,
    parameter int ZERO_REG_EN = 1,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_W-1:0]         w_en,
    input  logic [NUM_W*AW-1:0]      w_addr,
    input  logic [NUM_W*DATA_W-1:0]  w_data,
    output logic [NUM_W-1:0]         w_drop,
    input  logic [NUM_R-1:0]         r_en,
    input  logic [NUM_R*AW-1:0]      r_addr,
    output logic [NUM_R*DATA_W-1:0]  r_data,
    output logic [NUM_R-1:0]         r_vld,
    output logic                     rf_rdy
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       clr_ptr;
    logic                clr_last;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [AW-1:0]       wa [NUM_W];
    logic [DATA_W-1:0]   wd [NUM_W];
    logic [AW-1:0]       ra [NUM_R];
    logic [DATA_W-1:0]   rd_nxt [NUM_R];
    logic [NUM_W-1:0]    w_shadow;
    logic [NUM_W-1:0]    w_zero;
    logic [NUM_W-1:0]    w_eff;

    assign rf_rdy   = (state == ST_READY);
    assign clr_last = (clr_ptr == AW'(DEPTH - CLR_PER_CYC));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR)
                clr_ptr <= clr_ptr + AW'(CLR_PER_CYC);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_last)
            state_nxt = ST_READY;
    end

    always_comb begin
        for (int i = 0; i < NUM_W; i++) begin
            wa[i] = w_addr[i*AW +: AW];
            wd[i] = w_data[i*DATA_W +: DATA_W];
        end
        for (int k = 0; k < NUM_R; k++)
            ra[k] = r_addr[k*AW +: AW];
    end

    // Higher port index is the younger retire slot, so it shadows older same-address writes.
    always_comb begin
        w_shadow = '0;
        w_zero   = '0;
        w_eff    = '0;
        w_drop   = '0;
        for (int i = 0; i < NUM_W; i++) begin
            for (int j = i + 1; j < NUM_W; j++)
                if (w_en[j] && wa[j] == wa[i])
                    w_shadow[i] = 1'b1;
            w_zero[i] = (ZERO_REG_EN != 0) && (wa[i] == '0);
            w_eff[i]  = rf_rdy && w_en[i] && !w_shadow[i] && !w_zero[i];
            w_drop[i] = rf_rdy && w_en[i] &&  w_shadow[i] && !w_zero[i];
        end
    end

    // Array has no reset; contents are defined only by the clear sweep and effective writes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                for (int c = 0; c < CLR_PER_CYC; c++)
                    mem[clr_ptr + AW'(c)] <= '0;
            end else begin
                for (int i = 0; i < NUM_W; i++)
                    if (w_eff[i])
                        mem[wa[i]] <= wd[i];
            end
        end
    end

    // Effective writes target distinct addresses, so at most one bypass source can match.
    always_comb begin
        for (int k = 0; k < NUM_R; k++) begin
            rd_nxt[k] = mem[ra[k]];
            if (BYPASS_EN != 0)
                for (int i = 0; i < NUM_W; i++)
                    if (w_eff[i] && wa[i] == ra[k])
                        rd_nxt[k] = wd[i];
            if (ZERO_REG_EN != 0 && ra[k] == '0)
                rd_nxt[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_data <= '0;
        end else begin
            for (int k = 0; k < NUM_R; k++) begin
                r_vld[k] <= rf_rdy && r_en[k];
                if (rf_rdy && r_en[k])
                    r_data[k*DATA_W +: DATA_W] <= rd_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_prf_regfile_mp.sv
// Bench for prf_regfile_mp: a bypass and a non-bypass instance share stimulus; a reference model
// feeds a one-deep scoreboard queue, plus a vector table and hand sequences for clear/reset corners.
module tb_prf_regfile_mp;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    w_en;
    logic [23:0]   w_addr;
    logic [127:0]  w_data;
    logic [7:0]    r_en;
    logic [47:0]   r_addr;
    logic [3:0]    w_drop, w_drop_nb;
    logic [255:0]  r_data, r_data_nb;
    logic [7:0]    r_vld, r_vld_nb;
    logic          rf_rdy, rf_rdy_nb;

    always #5 clk = ~clk;

    prf_regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_drop(w_drop),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_vld(r_vld), .rf_rdy(rf_rdy)
    );

    prf_regfile_mp #(.BYPASS_EN(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_drop(w_drop_nb),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data_nb), .r_vld(r_vld_nb), .rf_rdy(rf_rdy_nb)
    );

    typedef struct {
        logic [7:0]   vld;
        logic [255:0] dat_bp;
        logic [255:0] dat_nb;
        logic         rdy;
    } sb_t;

    typedef struct {
        logic [3:0]   we;
        logic [23:0]  wa;
        logic [127:0] wd;
        logic [1:0]   re;
        logic [11:0]  ra;
        logic [3:0]   drop;
        logic [31:0]  r0_bp, r0_nb, r1_bp, r1_nb;
    } vec_t;

    sb_t          sbq[$];
    logic [31:0]  m_mem [64];
    logic         m_rdy = 1'b0;
    int           m_clr = 0;
    logic [255:0] last_bp = '0, last_nb = '0;
    int           n_cmp = 0, n_err = 0;
    vec_t         tbl [12];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        w_en = '0; w_addr = '0; w_data = '0; r_en = '0; r_addr = '0;
    endtask

    task automatic setw(input int p, input int a, input logic [31:0] d);
        w_en[p] = 1'b1;
        w_addr[p*6 +: 6] = a[5:0];
        w_data[p*32 +: 32] = d;
    endtask

    task automatic setr(input int p, input int a);
        r_en[p] = 1'b1;
        r_addr[p*6 +: 6] = a[5:0];
    endtask

    // Model predicts the post-edge outputs, pushes them, then the edge is taken and the entry popped.
    task automatic tick();
        sb_t e;
        logic [31:0] nxt [64];
        logic [5:0] a;
        e.vld = '0; e.dat_bp = last_bp; e.dat_nb = last_nb;
        if (!rst_n) begin
            m_rdy = 1'b0; m_clr = 0; e.dat_bp = '0; e.dat_nb = '0;
        end else if (!m_rdy) begin
            m_clr++;
            if (m_clr == 8) begin
                m_rdy = 1'b1;
                for (int i = 0; i < 64; i++) m_mem[i] = '0;
            end
        end else begin
            nxt = m_mem;
            for (int i = 0; i < 4; i++)
                if (w_en[i] && w_addr[i*6 +: 6] != 6'd0)
                    nxt[w_addr[i*6 +: 6]] = w_data[i*32 +: 32];
            for (int k = 0; k < 8; k++)
                if (r_en[k]) begin
                    a = r_addr[k*6 +: 6];
                    e.vld[k] = 1'b1;
                    e.dat_bp[k*32 +: 32] = nxt[a];
                    e.dat_nb[k*32 +: 32] = m_mem[a];
                end
            m_mem = nxt;
        end
        e.rdy = m_rdy;
        last_bp = e.dat_bp; last_nb = e.dat_nb;
        sbq.push_back(e);
        @(posedge clk); #1;
        e = sbq.pop_front();
        chk("rf_rdy", rf_rdy, e.rdy);
        chk("rf_rdy_nb", rf_rdy_nb, e.rdy);
        chk("r_vld", r_vld, e.vld);
        chk("r_vld_nb", r_vld_nb, e.vld);
        chk("r_data", r_data, e.dat_bp);
        chk("r_data_nb", r_data_nb, e.dat_nb);
    endtask

    task automatic wait_rdy(input string nm);
        int cnt = 0;
        while (!rf_rdy && cnt < 20) begin
            tick();
            cnt++;
        end
        chk(nm, cnt, 8);
    endtask

    function automatic vec_t mkv(logic [3:0] we, logic [23:0] wa, logic [127:0] wd, logic [1:0] re,
                                 logic [11:0] ra, logic [3:0] drop, logic [31:0] r0_bp,
                                 logic [31:0] r0_nb, logic [31:0] r1_bp, logic [31:0] r1_nb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.drop = drop;
        v.r0_bp = r0_bp; v.r0_nb = r0_nb; v.r1_bp = r1_bp; v.r1_nb = r1_nb;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mkv(4'b1011, {6'd5, 6'd0, 6'd9, 6'd5}, {32'hBBBB, 32'h0, 32'h1111, 32'hAAAA},
                      2'b01, {6'd0, 6'd5}, 4'b0001, 32'hBBBB, 32'h0, 32'h0, 32'h0);
        tbl[1]  = mkv(4'b0000, 24'd0, 128'd0, 2'b11, {6'd9, 6'd5}, 4'b0000,
                      32'hBBBB, 32'hBBBB, 32'h1111, 32'h1111);
        tbl[2]  = mkv(4'b0001, {18'd0, 6'd12}, {96'd0, 32'hDEAD}, 2'b01, {6'd0, 6'd12}, 4'b0000,
                      32'hDEAD, 32'h0, 32'h0, 32'h0);
        tbl[3]  = mkv(4'b0000, 24'd0, 128'd0, 2'b01, {6'd0, 6'd12}, 4'b0000,
                      32'hDEAD, 32'hDEAD, 32'h0, 32'h0);
        tbl[4]  = mkv(4'b0100, 24'd0, {32'h0, 32'hFFFF_FFFF, 64'd0}, 2'b01, 12'd0, 4'b0000,
                      32'h0, 32'h0, 32'h0, 32'h0);
        tbl[5]  = mkv(4'b0000, 24'd0, 128'd0, 2'b01, 12'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
        tbl[6]  = mkv(4'b0111, {6'd0, 6'd20, 6'd20, 6'd21}, {32'h0, 32'h6666, 32'h5555, 32'h7},
                      2'b11, {6'd21, 6'd20}, 4'b0010, 32'h6666, 32'h0, 32'h7, 32'h0);
        tbl[7]  = mkv(4'b1001, {6'd22, 6'd0, 6'd0, 6'd20}, {32'h2, 64'd0, 32'h1},
                      2'b11, {6'd21, 6'd20}, 4'b0000, 32'h1, 32'h6666, 32'h7, 32'h7);
        tbl[8]  = mkv(4'b1111, {6'd30, 6'd30, 6'd30, 6'd30}, {32'h13, 32'h12, 32'h11, 32'h10},
                      2'b01, {6'd0, 6'd30}, 4'b0111, 32'h13, 32'h0, 32'h0, 32'h0);
        tbl[9]  = mkv(4'b0000, 24'd0, 128'd0, 2'b11, {6'd20, 6'd30}, 4'b0000,
                      32'h13, 32'h13, 32'h1, 32'h1);
        tbl[10] = mkv(4'b0110, {6'd0, 6'd63, 6'd63, 6'd0}, {32'h0, 32'hCAFE, 32'h1, 32'h0},
                      2'b11, {6'd62, 6'd63}, 4'b0010, 32'hCAFE, 32'h0, 32'h0, 32'h0);
        tbl[11] = mkv(4'b0000, 24'd0, 128'd0, 2'b01, {6'd0, 6'd63}, 4'b0000,
                      32'hCAFE, 32'hCAFE, 32'h0, 32'h0);

        // Power-on reset: two reset cycles, then eight clear cycles before rf_rdy.
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wait_rdy("rdy_latency_por");

        for (int b = 0; b < 8; b++) begin
            idle();
            for (int k = 0; k < 8; k++) setr(k, b*8 + k);
            tick();
            chk("clr_read_data", r_data, 256'd0);
            chk("clr_read_vld", r_vld, 8'hFF);
        end

        for (int v = 0; v < 12; v++) begin
            w_en = tbl[v].we; w_addr = tbl[v].wa; w_data = tbl[v].wd;
            r_en = {6'd0, tbl[v].re}; r_addr = {36'd0, tbl[v].ra};
            #1;
            chk($sformatf("w_drop[%0d]", v), w_drop, tbl[v].drop);
            chk($sformatf("w_drop_nb[%0d]", v), w_drop_nb, tbl[v].drop);
            tick();
            if (tbl[v].re[0]) begin
                chk($sformatf("r0_bp[%0d]", v), r_data[31:0], tbl[v].r0_bp);
                chk($sformatf("r0_nb[%0d]", v), r_data_nb[31:0], tbl[v].r0_nb);
            end
            if (tbl[v].re[1]) begin
                chk($sformatf("r1_bp[%0d]", v), r_data[63:32], tbl[v].r1_bp);
                chk($sformatf("r1_nb[%0d]", v), r_data_nb[63:32], tbl[v].r1_nb);
            end
        end

        // All read ports on one address, then idle: r_vld drops and r_data holds.
        idle();
        setw(0, 7, 32'h77);
        tick();
        idle();
        for (int k = 0; k < 8; k++) setr(k, 7);
        tick();
        chk("fan_data", r_data, {8{32'h77}});
        chk("fan_vld", r_vld, 8'hFF);
        idle();
        tick();
        chk("hold_data", r_data, {8{32'h77}});
        chk("hold_vld", r_vld, 8'h00);

        // Reset re-asserted mid-clear restarts the sweep; requests during clear are ignored.
        idle();
        setw(0, 40, 32'h1234);
        tick();
        idle();
        setr(0, 40);
        tick();
        chk("rd40_pre", r_data[31:0], 32'h1234);
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            idle();
            setw(0, 40, 32'h9999);
            setw(1, 40, 32'h8888);
            for (int k = 0; k < 8; k++) setr(k, 40);
            #1;
            chk("clr_w_drop", w_drop, 4'b0000);
            tick();
            chk("clr_r_vld", r_vld, 8'h00);
        end
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_rdy("rdy_latency_midclr");
        idle();
        setw(0, 41, 32'h41);
        setr(0, 40);
        tick();
        chk("rd40_post", r_data[31:0], 32'h0);
        chk("rd40_vld", r_vld[0], 1'b1);
        idle();
        setr(0, 41);
        tick();
        chk("rd41_first_rdy_write", r_data[31:0], 32'h41);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
